// File: rtl/sd_stream_pkg.sv
// sd_stream_pkg: shared types for the SD stream client.
// FSM encoding and default block geometry.
package sd_stream_pkg;

  localparam int SD_BLOCK_BYTES = 512;
  localparam int SD_CNT_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ_LO,
    RD_CAP_LO,
    RD_REQ_HI,
    RD_CAP_HI,
    RD_OUT,
    WR_ACC,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  function automatic logic is_busy(state_t s);
    return !(s == IDLE || s == DONE);
  endfunction

endpackage

// File: rtl/sd_stream_client.sv
// sd_stream_client: FIFO-mux interface 1 initiator.
// Packs SD bytes into 16-bit LE samples and splits samples back to bytes.
module sd_stream_client
  import sd_stream_pkg::*;
#(
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter int CNT_W = SD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_en1,
  input  logic [7:0]       rd_dat1,
  input  logic             rd_empty,
  output logic             wr_en1,
  output logic [7:0]       wr_dat1,
  input  logic             wr_full,
  output logic [15:0]      m_sample,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic [15:0]      s_sample,
  input  logic             s_valid,
  output logic             s_ready
);

  localparam int BC_W = $clog2(BLOCK_BYTES);
  localparam logic [BC_W-1:0] LAST_PAIR =
    BC_W'(BLOCK_BYTES - 2);

  state_t           state;
  logic [BC_W-1:0]  byte_cnt;
  logic [CNT_W-1:0] blk_cnt;
  logic [CNT_W-1:0] nblk;
  logic [15:0]      sample;
  logic             blk_end;
  logic             last_blk;
  logic             rd_req;
  logic             wr_req;

  assign blk_end  = byte_cnt == LAST_PAIR;
  assign last_blk = blk_end &&
                    (blk_cnt + CNT_W'(1) == nblk);

  assign rd_req = state == RD_REQ_LO ||
                  state == RD_REQ_HI;
  assign wr_req = state == WR_LO ||
                  state == WR_HI;

  // Strobes are dropped in an abort cycle so nothing
  // leaves or enters the FIFOs once abort is seen.
  assign rd_en1 = rd_req && !rd_empty && !abort;
  assign wr_en1 = wr_req && !wr_full && !abort;

  always_comb begin
    wr_dat1 = sample[7:0];
    unique case (1'b1)
      state == WR_HI: wr_dat1 = sample[15:8];
      default:        wr_dat1 = sample[7:0];
    endcase
  end

  assign busy     = is_busy(state);
  assign done     = state == DONE;
  assign m_valid  = state == RD_OUT;
  assign s_ready  = state == WR_ACC;
  assign m_sample = sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      blk_cnt  <= '0;
      nblk     <= '0;
      sample   <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (num_blocks == '0) begin
              state <= DONE;
            end else begin
              nblk     <= num_blocks;
              byte_cnt <= '0;
              blk_cnt  <= '0;
              state    <= dir ? WR_ACC : RD_REQ_LO;
            end
          end
        end
        RD_REQ_LO: begin
          if (!rd_empty) state <= RD_CAP_LO;
        end
        RD_CAP_LO: begin
          sample[7:0] <= rd_dat1;
          state       <= RD_REQ_HI;
        end
        RD_REQ_HI: begin
          if (!rd_empty) state <= RD_CAP_HI;
        end
        RD_CAP_HI: begin
          sample[15:8] <= rd_dat1;
          state        <= RD_OUT;
        end
        RD_OUT: begin
          if (m_ready) begin
            if (blk_end) begin
              byte_cnt <= '0;
              blk_cnt  <= blk_cnt + CNT_W'(1);
            end else begin
              byte_cnt <= byte_cnt + BC_W'(2);
            end
            state <= last_blk ? DONE : RD_REQ_LO;
          end
        end
        WR_ACC: begin
          if (s_valid) begin
            sample <= s_sample;
            state  <= WR_LO;
          end
        end
        WR_LO: begin
          if (!wr_full) state <= WR_HI;
        end
        WR_HI: begin
          if (!wr_full) begin
            if (blk_end) begin
              byte_cnt <= '0;
              blk_cnt  <= blk_cnt + CNT_W'(1);
            end else begin
              byte_cnt <= byte_cnt + BC_W'(2);
            end
            state <= last_blk ? DONE : WR_ACC;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_stream_client.sv
// tb_sd_stream_client: randomized bench with FIFO and stream models.
// Expected data comes from the byte stream loaded into the read FIFO.
module tb_sd_stream_client;

  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic        dir = 0;
  logic [15:0] num_blocks = 0;
  logic        abort = 0;
  logic        busy, done;
  logic        rd_en1;
  logic [7:0]  rd_dat1 = 0;
  logic        rd_empty;
  logic        wr_en1;
  logic [7:0]  wr_dat1;
  logic        wr_full = 0;
  logic [15:0] m_sample;
  logic        m_valid;
  logic        m_ready = 1;
  logic [15:0] s_sample = 0;
  logic        s_valid = 0;
  logic        s_ready;

  sd_stream_client #(.BLOCK_BYTES(512), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir),
    .num_blocks(num_blocks), .abort(abort),
    .busy(busy), .done(done),
    .rd_en1(rd_en1), .rd_dat1(rd_dat1), .rd_empty(rd_empty),
    .wr_en1(wr_en1), .wr_dat1(wr_dat1), .wr_full(wr_full),
    .m_sample(m_sample), .m_valid(m_valid), .m_ready(m_ready),
    .s_sample(s_sample), .s_valid(s_valid), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  rd_mem [0:4095];
  logic [7:0]  wr_log [0:4095];
  logic [15:0] m_log  [0:4095];
  int rd_len = 0;
  int rd_ptr = 0;
  int wr_cnt = 0;
  int m_cnt = 0;
  int s_acc = 0;
  int s_base = 0;
  logic hold_empty = 0;
  logic bp_mode = 0;
  logic rec_mode = 0;

  assign rd_empty = (rd_ptr >= rd_len) || hold_empty;

  // FIFO and stream sinks updated on the active edge.
  always @(posedge clk) begin
    if (rd_en1) begin
      rd_dat1 <= rd_mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
    if (wr_en1) begin
      wr_log[wr_cnt] <= wr_dat1;
      wr_cnt <= wr_cnt + 1;
    end
    if (m_valid && m_ready) begin
      m_log[m_cnt] <= m_sample;
      m_cnt <= m_cnt + 1;
    end
    if (s_valid && s_ready) s_acc <= s_acc + 1;
  end

  int v_rd_empty = 0, v_rd_b2b = 0;
  int v_wr_full = 0, v_m_stable = 0;
  int rd_en_cnt = 0, wr_en_cnt = 0, done_cnt = 0;
  int cyc = 0;
  logic prev_rd = 0, prev_mv = 0, prev_mr = 0;
  logic [15:0] prev_ms = 0;

  // Protocol monitor, then drive next cycle's sink/source inputs.
  always @(negedge clk) begin
    if (rd_en1 && rd_empty) v_rd_empty++;
    if (rd_en1 && prev_rd) v_rd_b2b++;
    if (wr_en1 && wr_full) v_wr_full++;
    if (prev_mv && !prev_mr && !abort && !rst) begin
      if (m_valid !== 1'b1 || m_sample !== prev_ms)
        v_m_stable++;
    end
    if (rd_en1) rd_en_cnt++;
    if (wr_en1) wr_en_cnt++;
    if (done) done_cnt++;
    prev_rd = rd_en1;
    prev_mv = m_valid;
    prev_ms = m_sample;
    cyc++;
    m_ready = bp_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    prev_mr = m_ready;
    wr_full = rec_mode && (cyc % 7 == 0);
    s_valid = rec_mode && ($urandom_range(3, 0) != 0);
    s_sample = rec_mode ? 16'hA55A + 16'(s_acc - s_base) : 16'h0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic d, input logic [15:0] n);
    dir = d;
    num_blocks = n;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic load_bytes(input bit rnd, input int n);
    for (int i = 0; i < n; i++)
      rd_mem[rd_len + i] = rnd ? 8'($urandom) : 8'(i);
    rd_len = rd_len + n;
  endtask

  function automatic int pb_errs(input int mb, input int p0, input int n);
    int e = 0;
    logic [15:0] x;
    for (int j = 0; j < n; j++) begin
      x = {rd_mem[p0 + 2*j + 1], rd_mem[p0 + 2*j]};
      if (m_log[mb + j] !== x) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [29:0] o;
    #2 rst = 1;
    repeat (3) tick();
    o = {busy, done, rd_en1, wr_en1, wr_dat1,
         m_sample, m_valid, s_ready};
    n_chk++;
    if (o !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    rst = 0;
    tick();
    o = {busy, done, rd_en1, wr_en1, wr_dat1,
         m_sample, m_valid, s_ready};
    n_chk++;
    if (o !== 30'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h want 0", o);
    end
  endtask

  task automatic test_playback_one();
    int p0, mb, rb, db, vb, e;
    bit ok;
    p0 = rd_ptr;
    load_bytes(0, 512);
    mb = m_cnt; rb = rd_en_cnt; db = done_cnt;
    vb = v_rd_empty + v_rd_b2b + v_m_stable;
    start_xfer(0, 16'd1);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pb_busy: got %b want 1", busy);
    end
    wait_done(5000, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL pb_done_timeout: got none want done");
    end
    repeat (3) tick();
    n_chk++;
    if (m_cnt - mb != 256) begin
      n_fail++;
      $display("FAIL pb_count: got %0d want 256", m_cnt - mb);
    end
    n_chk++;
    if (m_log[mb] !== 16'h0100 || m_log[mb+1] !== 16'h0302) begin
      n_fail++;
      $display("FAIL pb_first: got %h %h want 0100 0302",
               m_log[mb], m_log[mb+1]);
    end
    e = pb_errs(mb, p0, 256);
    n_chk++;
    if (e != 0) begin
      n_fail++;
      $display("FAIL pb_data: got %0d bad samples want 0", e);
    end
    n_chk++;
    if (rd_en_cnt - rb != 512) begin
      n_fail++;
      $display("FAIL pb_pops: got %0d want 512", rd_en_cnt - rb);
    end
    n_chk++;
    if (done_cnt - db != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pb_done_once: got %0d busy %b want 1 busy 0",
               done_cnt - db, busy);
    end
    n_chk++;
    if (v_rd_empty + v_rd_b2b + v_m_stable != vb) begin
      n_fail++;
      $display("FAIL pb_protocol: got %0d violations want 0",
               v_rd_empty + v_rd_b2b + v_m_stable - vb);
    end
  endtask

  task automatic test_backpressure();
    int p0, mb, rb, db, ve, vs, e, re;
    bit ok;
    p0 = rd_ptr;
    load_bytes(1, 512);
    mb = m_cnt; rb = rd_en_cnt; db = done_cnt;
    ve = v_rd_empty + v_rd_b2b; vs = v_m_stable;
    re = 0;
    bp_mode = 1;
    start_xfer(0, 16'd1);
    for (int c = 0; c < 4000 && m_cnt - mb < 60; c++) tick();
    hold_empty = 1;
    repeat (10) begin
      tick();
      if (rd_en1) re++;
    end
    hold_empty = 0;
    wait_done(20000, ok);
    bp_mode = 0;
    repeat (3) tick();
    n_chk++;
    if (!ok || re != 0) begin
      n_fail++;
      $display("FAIL bp_done_or_hold: got ok=%0d pops=%0d want 1 0",
               ok, re);
    end
    e = pb_errs(mb, p0, 256);
    n_chk++;
    if (e != 0 || m_cnt - mb != 256) begin
      n_fail++;
      $display("FAIL bp_data: got %0d bad of %0d want 0 of 256",
               e, m_cnt - mb);
    end
    n_chk++;
    if (v_m_stable != vs) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d changes want 0",
               v_m_stable - vs);
    end
    n_chk++;
    if (v_rd_empty + v_rd_b2b != ve) begin
      n_fail++;
      $display("FAIL bp_rd_rules: got %0d want 0",
               v_rd_empty + v_rd_b2b - ve);
    end
    n_chk++;
    if (rd_en_cnt - rb != 512 || done_cnt - db != 1) begin
      n_fail++;
      $display("FAIL bp_counts: got pops %0d done %0d want 512 1",
               rd_en_cnt - rb, done_cnt - db);
    end
  endtask

  task automatic test_record_two();
    int wb, db, vb, e, at_done;
    bit ok;
    logic [15:0] x;
    s_base = s_acc;
    wb = wr_cnt; db = done_cnt; vb = v_wr_full;
    rec_mode = 1;
    start_xfer(1, 16'd2);
    wait_done(20000, ok);
    at_done = wr_cnt - wb;
    rec_mode = 0;
    repeat (4) tick();
    n_chk++;
    if (!ok || at_done != 1024) begin
      n_fail++;
      $display("FAIL rec_done: got ok=%0d pushes=%0d want 1 1024",
               ok, at_done);
    end
    n_chk++;
    if (wr_cnt - wb != 1024 || done_cnt - db != 1) begin
      n_fail++;
      $display("FAIL rec_counts: got %0d done %0d want 1024 1",
               wr_cnt - wb, done_cnt - db);
    end
    n_chk++;
    if (wr_log[wb] !== 8'h5A || wr_log[wb+1] !== 8'hA5 ||
        wr_log[wb+2] !== 8'h5B) begin
      n_fail++;
      $display("FAIL rec_first: got %h %h %h want 5a a5 5b",
               wr_log[wb], wr_log[wb+1], wr_log[wb+2]);
    end
    e = 0;
    for (int k = 0; k < 512; k++) begin
      x = 16'hA55A + 16'(k);
      if (wr_log[wb + 2*k] !== x[7:0]) e++;
      if (wr_log[wb + 2*k + 1] !== x[15:8]) e++;
    end
    n_chk++;
    if (e != 0) begin
      n_fail++;
      $display("FAIL rec_data: got %0d bad bytes want 0", e);
    end
    n_chk++;
    if (v_wr_full != vb || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rec_full: got %0d pushes while full busy %b want 0 0",
               v_wr_full - vb, busy);
    end
  endtask

  task automatic test_zero_blocks();
    int rb, wb, db;
    rb = rd_en_cnt; wb = wr_en_cnt; db = done_cnt;
    start_xfer(1'($urandom_range(1, 0)), 16'd0);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done %b busy %b want 1 0",
               done, busy);
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse: got %b want 0", done);
    end
    repeat (3) tick();
    n_chk++;
    if (rd_en_cnt != rb || wr_en_cnt != wb || done_cnt - db != 1) begin
      n_fail++;
      $display("FAIL zero_access: got rd %0d wr %0d done %0d want 0 0 1",
               rd_en_cnt - rb, wr_en_cnt - wb, done_cnt - db);
    end
  endtask

  task automatic test_abort();
    int mb, rb, db, p0, e;
    bit ok;
    load_bytes(1, 512);
    mb = m_cnt;
    start_xfer(0, 16'd1);
    for (int c = 0; c < 3000 && m_cnt - mb < 100; c++) tick();
    n_chk++;
    if (m_cnt - mb < 100) begin
      n_fail++;
      $display("FAIL abort_reach: got %0d samples want 100", m_cnt - mb);
    end
    db = done_cnt;
    abort = 1;
    tick();
    abort = 0;
    n_chk++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy %b m_valid %b want 0 0",
               busy, m_valid);
    end
    rb = rd_en_cnt;
    repeat (20) tick();
    n_chk++;
    if (rd_en_cnt != rb || done_cnt != db || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got rd %0d done %0d want 0 0",
               rd_en_cnt - rb, done_cnt - db);
    end
    load_bytes(1, 512);
    p0 = rd_ptr;
    mb = m_cnt;
    db = done_cnt;
    start_xfer(0, 16'd1);
    wait_done(5000, ok);
    repeat (3) tick();
    e = pb_errs(mb, p0, 256);
    n_chk++;
    if (!ok || e != 0 || m_cnt - mb != 256 || done_cnt - db != 1) begin
      n_fail++;
      $display("FAIL abort_restart: got ok=%0d bad=%0d n=%0d want 1 0 256",
               ok, e, m_cnt - mb);
    end
  endtask

  task automatic test_async_reset();
    int k, rb;
    logic [29:0] o;
    load_bytes(1, 512);
    start_xfer(0, 16'd1);
    k = 0;
    for (int c = 0; c < 2000 && k < 10; c++) begin
      tick();
      if (rd_en1) k++;
    end
    @(posedge clk);
    #1;
    rst = 1;
    start = 1;
    #1;
    o = {busy, done, rd_en1, wr_en1, wr_dat1,
         m_sample, m_valid, s_ready};
    n_chk++;
    if (k != 10 || o !== 30'd0) begin
      n_fail++;
      $display("FAIL arst_outputs: got %h k=%0d want 0 k=10", o, k);
    end
    repeat (3) tick();
    o = {busy, done, rd_en1, wr_en1, wr_dat1,
         m_sample, m_valid, s_ready};
    n_chk++;
    if (o !== 30'd0) begin
      n_fail++;
      $display("FAIL arst_start_ignored: got %h want 0", o);
    end
    start = 0;
    rst = 0;
    rb = rd_en_cnt;
    repeat (5) tick();
    n_chk++;
    if (busy !== 1'b0 || rd_en_cnt != rb) begin
      n_fail++;
      $display("FAIL arst_idle: got busy %b rd %0d want 0 0",
               busy, rd_en_cnt - rb);
    end
  endtask

  initial begin
    test_reset();
    test_playback_one();
    test_backpressure();
    test_record_two();
    test_zero_blocks();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
